// File: rtl/unidad_muldiv.sv
// RV32M multiply/divide unit: iterative shift-add multiply and restoring divide,
// one bit per cycle, fixed latency for every op including the special cases.
module unidad_muldiv (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    input  logic [4:0]  rd_i,
    output logic        busy_o,
    output logic [4:0]  rd_o,
    output logic [31:0] datard_o,
    output logic        wren_o
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    state_t      state_reg, state_next;
    logic [4:0]  cnt_reg;
    logic [2:0]  op_reg;
    logic [4:0]  rd_reg;
    logic [31:0] a_reg;
    logic [31:0] ma_reg;
    logic [31:0] mb_reg;
    logic [63:0] acc_reg;
    logic        neg_q_reg;
    logic        neg_r_reg;
    logic        dz_reg;
    logic        busy_reg;
    logic        wren_reg;
    logic [4:0]  rd_out_reg;
    logic [31:0] data_reg;

    // Operand decode for the request being presented
    logic        a_signed, b_signed, a_neg, b_neg, is_div;
    logic [31:0] a_mag, b_mag;

    always_comb begin
        is_div   = funct3_i[2];
        a_signed = (funct3_i == OP_MULH) || (funct3_i == OP_MULHSU) ||
                   (funct3_i == OP_DIV)  || (funct3_i == OP_REM);
        b_signed = (funct3_i == OP_MULH) || (funct3_i == OP_DIV) || (funct3_i == OP_REM);
        a_neg    = a_signed && rs1_data_i[31];
        b_neg    = b_signed && rs2_data_i[31];
        a_mag    = a_neg ? (~rs1_data_i + 32'd1) : rs1_data_i;
        b_mag    = b_neg ? (~rs2_data_i + 32'd1) : rs2_data_i;
    end

    // One iteration step; acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] rem_shift;
    logic [32:0] rem_sub;
    logic        ge;
    logic [63:0] div_next;

    always_comb begin
        mul_sum   = {1'b0, acc_reg[63:32]} + (acc_reg[0] ? {1'b0, ma_reg} : 33'd0);
        mul_next  = {mul_sum, acc_reg[31:1]};
        rem_shift = acc_reg[63:31];
        rem_sub   = rem_shift - {1'b0, mb_reg};
        // remainder < divisor keeps a non-negative difference below 2^32
        ge        = ~rem_sub[32];
        div_next  = {(ge ? rem_sub[31:0] : rem_shift[31:0]), acc_reg[30:0], ge};
    end

    // Sign fix-up and special cases applied in DONE
    logic [63:0] prod;
    logic [31:0] quo, rem, result;

    always_comb begin
        prod   = neg_q_reg ? (~acc_reg + 64'd1) : acc_reg;
        quo    = neg_q_reg ? (~acc_reg[31:0] + 32'd1) : acc_reg[31:0];
        rem    = neg_r_reg ? (~acc_reg[63:32] + 32'd1) : acc_reg[63:32];
        result = 32'd0;
        case (op_reg)
            OP_MUL:                      result = prod[31:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result = prod[63:32];
            OP_DIV, OP_DIVU:             result = dz_reg ? 32'hFFFF_FFFF : quo;
            OP_REM, OP_REMU:             result = dz_reg ? a_reg : rem;
            default:                     result = 32'd0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_i) state_next = CALC;
            CALC:    if (cnt_reg == 5'd31) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_reg    <= 5'd0;
            op_reg     <= 3'd0;
            rd_reg     <= 5'd0;
            a_reg      <= 32'd0;
            ma_reg     <= 32'd0;
            mb_reg     <= 32'd0;
            acc_reg    <= 64'd0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            dz_reg     <= 1'b0;
            busy_reg   <= 1'b0;
            wren_reg   <= 1'b0;
            rd_out_reg <= 5'd0;
            data_reg   <= 32'd0;
        end else begin
            busy_reg <= (state_reg != IDLE);
            wren_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start_i) begin
                        cnt_reg   <= 5'd0;
                        op_reg    <= funct3_i;
                        rd_reg    <= rd_i;
                        a_reg     <= rs1_data_i;
                        ma_reg    <= a_mag;
                        mb_reg    <= b_mag;
                        acc_reg   <= is_div ? {32'd0, a_mag} : {32'd0, b_mag};
                        neg_q_reg <= a_neg ^ b_neg;
                        neg_r_reg <= a_neg;
                        dz_reg    <= (rs2_data_i == 32'd0);
                    end
                end
                CALC: begin
                    cnt_reg <= cnt_reg + 5'd1;
                    acc_reg <= op_reg[2] ? div_next : mul_next;
                end
                DONE: begin
                    rd_out_reg <= rd_reg;
                    data_reg   <= result;
                    wren_reg   <= (rd_reg != 5'd0);
                end
                default: ;
            endcase
        end
    end

    assign busy_o   = busy_reg;
    assign wren_o   = wren_reg;
    assign rd_o     = rd_out_reg;
    assign datard_o = data_reg;

endmodule

// File: tb/tb_unidad_muldiv.sv
// Scoreboard bench for unidad_muldiv: directed RV32M corner cases plus random ops,
// checked against plain 64-bit arithmetic; a monitor pops on each completion.
module tb_unidad_muldiv;

    localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
    localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic [2:0]  funct3_i = 3'd0;
    logic [31:0] rs1_data_i = 32'd0;
    logic [31:0] rs2_data_i = 32'd0;
    logic [4:0]  rd_i = 5'd0;
    logic        busy_o;
    logic [4:0]  rd_o;
    logic [31:0] datard_o;
    logic        wren_o;

    unidad_muldiv dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .start_i    (start_i),
        .funct3_i   (funct3_i),
        .rs1_data_i (rs1_data_i),
        .rs2_data_i (rs2_data_i),
        .rd_i       (rd_i),
        .busy_o     (busy_o),
        .rd_o       (rd_o),
        .datard_o   (datard_o),
        .wren_o     (wren_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    // Reference model straight from the RV32M rules
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ub, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'd0, b});
        p  = 64'd0;
        case (f)
            MUL:    begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            MULH:   begin r = sa * sb; p = r; return p[63:32]; end
            MULHSU: begin r = sa * ub; p = r; return p[63:32]; end
            MULHU:  begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            DIV:    begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                r = sa / sb; p = r; return p[31:0];
            end
            DIVU:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            REM:    begin
                if (b == 32'd0) return a;
                r = sa % sb; p = r; return p[31:0];
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom % 6)
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return $urandom % 16;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: one completion per busy_o falling edge
    initial begin
        int   bcnt, wcnt, wat;
        logic busy_prev;
        exp_t e;
        bcnt = 0; wcnt = 0; wat = 0; busy_prev = 1'b0;
        forever begin
            @(posedge clk_i); #1;
            if (!rst_ni) begin
                bcnt = 0; wcnt = 0; wat = 0; busy_prev = 1'b0;
            end else begin
                if (busy_o) bcnt++;
                if (wren_o) begin
                    wcnt++;
                    wat = bcnt;
                end
                if (busy_prev && !busy_o) begin
                    if (q.size() == 0) begin
                        chk("unexpected_completion", {rd_o, datard_o}, 64'd0);
                    end else begin
                        e = q.pop_front();
                        $display("txn rd=%0d data=%h expect rd=%0d data=%h busy_cycles=%0d wren_pulses=%0d",
                                 rd_o, datard_o, e.rd, e.data, bcnt, wcnt);
                        chk("result", {27'd0, rd_o, datard_o}, {27'd0, e.rd, e.data});
                        chk("busy_cycles", bcnt, 33);
                        chk("wren_count", wcnt, (e.rd != 5'd0) ? 1 : 0);
                        if (e.rd != 5'd0) chk("wren_cycle", wat, 33);
                    end
                    bcnt = 0; wcnt = 0; wat = 0;
                end
                busy_prev = busy_o;
            end
        end
    end

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] expv);
        int t;
        exp_t e;
        funct3_i = f; rs1_data_i = a; rs2_data_i = b; rd_i = rd; start_i = 1'b1;
        e.rd = rd; e.data = expv;
        q.push_back(e);
        @(posedge clk_i); #1;
        start_i = 1'b0;
        funct3_i = 3'($urandom); rs1_data_i = $urandom; rs2_data_i = $urandom; rd_i = 5'($urandom);
        repeat (4) @(posedge clk_i);
        #1 start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        t = 0;
        while (busy_o && t < 60) begin
            @(posedge clk_i); #1;
            t++;
        end
        chk("completion_timeout", {63'd0, busy_o}, 64'd0);
    endtask

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] x;
    } vec_t;

    vec_t dir[$] = '{
        '{MUL,    32'd7,           32'd6,           5'd5,  32'h0000_002A},
        '{MULH,   32'hFFFF_FFFF,   32'hFFFF_FFFF,   5'd1,  32'h0000_0000},
        '{MULHU,  32'hFFFF_FFFF,   32'hFFFF_FFFF,   5'd2,  32'hFFFF_FFFE},
        '{MULHSU, 32'hFFFF_FFFF,   32'hFFFF_FFFF,   5'd3,  32'hFFFF_FFFF},
        '{MUL,    32'hFFFF_FFFF,   32'hFFFF_FFFF,   5'd4,  32'h0000_0001},
        '{DIV,    32'hFFFF_FFF9,   32'd2,           5'd6,  32'hFFFF_FFFD},
        '{REM,    32'hFFFF_FFF9,   32'd2,           5'd7,  32'hFFFF_FFFF},
        '{DIVU,   32'hFFFF_FFF9,   32'd2,           5'd8,  32'h7FFF_FFFC},
        '{REMU,   32'hFFFF_FFF9,   32'd2,           5'd9,  32'h0000_0001},
        '{DIVU,   32'd5,           32'd0,           5'd10, 32'hFFFF_FFFF},
        '{REMU,   32'd5,           32'd0,           5'd11, 32'h0000_0005},
        '{DIV,    32'h8000_0000,   32'hFFFF_FFFF,   5'd12, 32'h8000_0000},
        '{REM,    32'h8000_0000,   32'hFFFF_FFFF,   5'd13, 32'h0000_0000},
        '{DIV,    32'hFFFF_FFF9,   32'd0,           5'd14, 32'hFFFF_FFFF},
        '{REM,    32'hFFFF_FFF9,   32'd0,           5'd0,  32'hFFFF_FFF9}
    };

    initial begin
        logic [39:0] busy_seen, busy_want;
        logic [2:0]  f;
        logic [31:0] a, b;
        logic [4:0]  rd;
        int          t;

        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        chk("reset_busy", {63'd0, busy_o}, 64'd0);
        chk("reset_wren", {63'd0, wren_o}, 64'd0);
        chk("reset_rd_data", {27'd0, rd_o, datard_o}, 64'd0);
        rst_ni = 1'b1;

        foreach (dir[i]) issue(dir[i].f, dir[i].a, dir[i].b, dir[i].rd, dir[i].x);

        // Abort a MUL at edge 10 with an asynchronous reset
        funct3_i = MUL; rs1_data_i = 32'd3; rs2_data_i = 32'd5; rd_i = 5'd9; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (10) @(posedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        chk("async_reset_busy", {63'd0, busy_o}, 64'd0);
        chk("async_reset_wren", {63'd0, wren_o}, 64'd0);
        chk("async_reset_rd_data", {27'd0, rd_o, datard_o}, 64'd0);
        repeat (2) @(posedge clk_i);
        #1;
        chk("reset_held_wren", {63'd0, wren_o}, 64'd0);
        rst_ni = 1'b1;
        issue(MUL, 32'h0000_1234, 32'h0000_0010, 5'd7, 32'h0001_2340);

        // start_i held for 40 cycles: accepts at edge 0 and edge 34 only
        begin
            exp_t e;
            funct3_i = MUL; rs1_data_i = 32'd7; rs2_data_i = 32'd6; rd_i = 5'd5; start_i = 1'b1;
            e.rd = 5'd5; e.data = 32'h0000_002A;
            q.push_back(e);
            busy_seen = '0;
            for (int k = 0; k < 40; k++) begin
                @(posedge clk_i); #1;
                busy_seen[k] = busy_o;
                if (k == 0) begin
                    funct3_i = DIV; rs1_data_i = 32'hFFFF_FFF9; rs2_data_i = 32'd2; rd_i = 5'd0;
                    e.rd = 5'd0; e.data = 32'hFFFF_FFFD;
                    q.push_back(e);
                end
            end
            start_i = 1'b0;
            busy_want = '0;
            for (int k = 1; k < 40; k++) busy_want[k] = (k != 34);
            chk("held_start_busy_pattern", {24'd0, busy_seen}, {24'd0, busy_want});
            t = 0;
            while (busy_o && t < 60) begin
                @(posedge clk_i); #1;
                t++;
            end
            chk("held_start_drain", {63'd0, busy_o}, 64'd0);
        end

        // Random ops against the reference model
        for (int n = 0; n < 80; n++) begin
            f  = 3'($urandom);
            a  = pick();
            b  = pick();
            rd = 5'($urandom);
            issue(f, a, b, rd, model(f, a, b));
            repeat ($urandom % 3) @(posedge clk_i);
            #1;
        end

        t = 0;
        while (q.size() != 0 && t < 100) begin
            @(posedge clk_i); #1;
            t++;
        end
        chk("scoreboard_empty", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
